// File: rtl/lshifter_pipe.sv
// Iterative left shifter/rotator: loads one of NCH channel words, then shifts or rotates it
// one bit per clock. Optional macro LSHIFT_NIBBLE_EN lets SHIFT step by 4 while the count allows it.
module lshifter_pipe #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 16,
    parameter int NCH   = 2,
    parameter int SEL_W = 1,
    parameter int AMT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NCH*IN_W-1:0]   in_data,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic [AMT_W-1:0]      in_amt,
    input  logic                  in_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    output logic                  out_err,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state, state_nxt;
    logic [OUT_W-1:0]   data;
    logic [AMT_W-1:0]   cnt;
    logic               mode;
    logic [SEL_W-1:0]   ch;
    logic               err;

    logic [OUT_W-1:0]   word_ext;
    logic               sel_err;
    logic [OUT_W-1:0]   data_step;
    logic [AMT_W-1:0]   step;
    logic               last;

    function automatic logic [OUT_W-1:0] step1(input logic [OUT_W-1:0] d, input logic rot);
        step1 = {d[OUT_W-2:0], rot & d[OUT_W-1]};
    endfunction

`ifdef LSHIFT_NIBBLE_EN
    function automatic logic [OUT_W-1:0] step4(input logic [OUT_W-1:0] d, input logic rot);
        step4 = {d[OUT_W-5:0], rot ? d[OUT_W-1:OUT_W-4] : 4'b0000};
    endfunction
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // Channel select; an out-of-range select leaves zero data and flags the error.
    always_comb begin
        word_ext = '0;
        sel_err  = 1'b1;
        for (int k = 0; k < NCH; k++) begin
            if (in_sel == SEL_W'(k)) begin
                word_ext = OUT_W'(in_data[k*IN_W +: IN_W]);
                sel_err  = 1'b0;
            end
        end
    end

    always_comb begin
`ifdef LSHIFT_NIBBLE_EN
        if (32'(cnt) >= 4) begin
            data_step = step4(data, mode);
            step      = AMT_W'(4);
        end else begin
            data_step = step1(data, mode);
            step      = AMT_W'(1);
        end
`else
        data_step = step1(data, mode);
        step      = AMT_W'(1);
`endif
        last = (cnt == step);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = (in_amt == '0) ? DONE : SHIFT;
            SHIFT:   if (last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Working registers plus a separate result register that only changes on entry to DONE,
    // so out_data is stable for the whole handshake and keeps its value afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data     <= '0;
            cnt      <= '0;
            mode     <= 1'b0;
            ch       <= '0;
            err      <= 1'b0;
            out_data <= '0;
            out_ch   <= '0;
            out_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data <= word_ext;
                        cnt  <= in_amt;
                        mode <= in_mode;
                        ch   <= in_sel;
                        err  <= sel_err;
                        if (in_amt == '0) begin
                            out_data <= word_ext;
                            out_ch   <= in_sel;
                            out_err  <= sel_err;
                        end
                    end
                end
                SHIFT: begin
                    data <= data_step;
                    cnt  <= cnt - step;
                    if (last) begin
                        out_data <= data_step;
                        out_ch   <= ch;
                        out_err  <= err;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lshifter_pipe.sv
// Directed testbench for lshifter_pipe: a default NCH=2 instance and an NCH=1 instance
// for the invalid-select case.
module tb_lshifter_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic        in_sel = 1'b0;
    logic [3:0]  in_amt = '0;
    logic        in_mode = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_ch;
    logic        out_err;
    logic        busy;

    logic        v1_in_valid = 1'b0;
    logic        v1_in_ready;
    logic [3:0]  v1_in_data = '0;
    logic        v1_in_sel = 1'b0;
    logic [3:0]  v1_in_amt = '0;
    logic        v1_in_mode = 1'b0;
    logic        v1_out_valid;
    logic        v1_out_ready = 1'b0;
    logic [15:0] v1_out_data;
    logic        v1_out_ch;
    logic        v1_out_err;
    logic        v1_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lshifter_pipe #(.IN_W(4), .OUT_W(16), .NCH(2), .SEL_W(1), .AMT_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .in_amt(in_amt), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ch(out_ch), .out_err(out_err), .busy(busy)
    );

    lshifter_pipe #(.IN_W(4), .OUT_W(16), .NCH(1), .SEL_W(1), .AMT_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1_in_valid), .in_ready(v1_in_ready),
        .in_data(v1_in_data), .in_sel(v1_in_sel), .in_amt(v1_in_amt), .in_mode(v1_in_mode),
        .out_valid(v1_out_valid), .out_ready(v1_out_ready), .out_data(v1_out_data),
        .out_ch(v1_out_ch), .out_err(v1_out_err), .busy(v1_busy)
    );

    // Spec-level latency: cycles from the accepting edge (counted as 1) to out_valid.
    function automatic int exp_lat(input int amt);
`ifdef LSHIFT_NIBBLE_EN
        return amt / 4 + amt % 4 + 1;
`else
        return amt + 1;
`endif
    endfunction

    task automatic run0(input logic [7:0] din, input logic sel, input logic [3:0] amt,
                        input logic mode, output int lat);
        @(negedge clk);
        in_data = din; in_sel = sel; in_amt = amt; in_mode = mode; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 200) begin
            errors++;
            $display("FAIL timeout waiting for out_valid: got none after %0d cycles, required %0d", lat, exp_lat(int'(amt)));
        end
    endtask

    task automatic release0();
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b required 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b required 0", out_valid); end
        checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data got %h required 0000", out_data); end
        checks++; if ({out_ch, out_err, busy} !== 3'b000) begin errors++; $display("FAIL reset_ch_err_busy got %b required 000", {out_ch, out_err, busy}); end
    endtask

    task automatic test_logical();
        int lat;
        run0({4'd0, 4'd13}, 1'b0, 4'd3, 1'b0, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL logical_latency got %0d required 4", lat); end
        checks++; if (out_data !== 16'h0068) begin errors++; $display("FAIL logical_data got %h required 0068", out_data); end
        checks++; if ({out_ch, out_err} !== 2'b00) begin errors++; $display("FAIL logical_ch_err got %b required 00", {out_ch, out_err}); end
        checks++; if ({busy, in_ready} !== 2'b10) begin errors++; $display("FAIL logical_busy_ready got %b required 10", {busy, in_ready}); end
        release0();
        checks++; if ({out_valid, in_ready, busy} !== 3'b010) begin errors++; $display("FAIL logical_after_hs got %b required 010", {out_valid, in_ready, busy}); end
        checks++; if (out_data !== 16'h0068) begin errors++; $display("FAIL logical_data_kept got %h required 0068", out_data); end
    endtask

    task automatic test_rotate();
        int lat;
        run0({4'd8, 4'd0}, 1'b1, 4'd13, 1'b1, lat);
        checks++; if (lat !== exp_lat(13)) begin errors++; $display("FAIL rotate_latency got %0d required %0d", lat, exp_lat(13)); end
        checks++; if (out_data !== 16'h0001) begin errors++; $display("FAIL rotate_wrap_data got %h required 0001", out_data); end
        checks++; if (out_ch !== 1'b1) begin errors++; $display("FAIL rotate_ch got %b required 1", out_ch); end
        release0();
        run0({4'hB, 4'd0}, 1'b1, 4'd14, 1'b1, lat);
        checks++; if (out_data !== 16'hC002) begin errors++; $display("FAIL rotate14_data got %h required c002", out_data); end
        release0();
    endtask

    task automatic test_max_amount();
        int lat;
        run0({4'd0, 4'd13}, 1'b0, 4'd15, 1'b0, lat);
        checks++; if (lat !== exp_lat(15)) begin errors++; $display("FAIL max_latency got %0d required %0d", lat, exp_lat(15)); end
        checks++; if (out_data !== 16'h8000) begin errors++; $display("FAIL max_data got %h required 8000", out_data); end
        release0();
    endtask

    task automatic test_zero_amount();
        int lat;
        run0({4'd0, 4'd13}, 1'b0, 4'd0, 1'b1, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL zero_latency got %0d required 1", lat); end
        checks++; if (out_data !== 16'h000D) begin errors++; $display("FAIL zero_data got %h required 000d", out_data); end
        release0();
    endtask

    task automatic test_backpressure();
        int lat;
        @(negedge clk);
        in_data = {4'h5, 4'hF}; in_sel = 1'b1; in_amt = 4'd2; in_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        // Keep a different request asserted while the first is in flight; it must be ignored.
        in_sel = 1'b0; in_amt = 4'd0; in_data = {4'h0, 4'hF};
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 200) begin errors++; $display("FAIL bp_timeout got no out_valid required valid"); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({out_valid, in_ready, out_ch, out_data} !== {1'b1, 1'b0, 1'b1, 16'h0014}) begin
                errors++;
                $display("FAIL bp_hold_%0d got v=%b rdy=%b ch=%b d=%h required v=1 rdy=0 ch=1 d=0014",
                         i, out_valid, in_ready, out_ch, out_data);
            end
        end
        in_valid = 1'b0;
        release0();
        @(posedge clk); #1;
        checks++; if ({out_valid, busy, out_data} !== {1'b0, 1'b0, 16'h0014}) begin errors++; $display("FAIL bp_no_extra_accept got v=%b busy=%b d=%h required v=0 busy=0 d=0014", out_valid, busy, out_data); end
    endtask

    task automatic test_invalid_sel();
        int lat;
        @(negedge clk);
        v1_in_data = 4'hF; v1_in_sel = 1'b1; v1_in_amt = 4'd2; v1_in_mode = 1'b1; v1_in_valid = 1'b1;
        @(posedge clk); #1;
        v1_in_valid = 1'b0;
        lat = 1;
        while (v1_out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (lat !== exp_lat(2)) begin errors++; $display("FAIL err_latency got %0d required %0d", lat, exp_lat(2)); end
        checks++; if ({v1_out_err, v1_out_data} !== {1'b1, 16'h0000}) begin errors++; $display("FAIL err_flag_data got err=%b d=%h required err=1 d=0000", v1_out_err, v1_out_data); end
        @(negedge clk); v1_out_ready = 1'b1;
        @(posedge clk); #1; v1_out_ready = 1'b0;
        @(negedge clk);
        v1_in_data = 4'h3; v1_in_sel = 1'b0; v1_in_amt = 4'd1; v1_in_mode = 1'b0; v1_in_valid = 1'b1;
        @(posedge clk); #1;
        v1_in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if ({v1_out_valid, v1_out_err, v1_out_data} !== {1'b1, 1'b0, 16'h0006}) begin errors++; $display("FAIL err_valid_sel got v=%b err=%b d=%h required v=1 err=0 d=0006", v1_out_valid, v1_out_err, v1_out_data); end
        @(negedge clk); v1_out_ready = 1'b1;
        @(posedge clk); #1; v1_out_ready = 1'b0;
    endtask

    task automatic test_reset_abort();
        int seen;
        @(negedge clk);
        in_data = {4'd0, 4'd13}; in_sel = 1'b0; in_amt = 4'd10; in_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before got %b required 1", busy); end
        @(negedge clk); rst_n = 1'b0;
        #1;
        checks++; if ({out_valid, busy, in_ready} !== 3'b001) begin errors++; $display("FAIL abort_in_reset got %b required 001", {out_valid, busy, in_ready}); end
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1 || busy === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_stale_result got %0d active cycles required 0", seen); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready got %b required 1", in_ready); end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        test_logical();
        test_rotate();
        test_max_amount();
        test_zero_amount();
        test_backpressure();
        test_invalid_sel();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lshifter_pipe.md
Name: lshifter_pipe

Overview:
Parametrised iterative left shifter/rotator, the successor to the fixed two-input 4-to-16-bit lshifter. It accepts one word from NCH input channels through a valid/ready handshake and zero-extends it to OUT_W. It then shifts the word left logically or rotates it by a runtime amount, one bit position per clock. The result is presented through a valid/ready output handshake, and the block sits between operand muxing and downstream datapath consumers.

Parameters:
- IN_W, 4, width of each input channel word
- OUT_W, 16, width of the shifted result; must be >= IN_W
- NCH, 2, number of input channels
- SEL_W, 1, width of the channel select; 2**SEL_W >= NCH
- AMT_W, 4, width of the shift amount

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request
- in_data  input  NCH*IN_W  packed channel words; channel k at [k*IN_W +: IN_W]
- in_sel  input  SEL_W  channel to load
- in_amt  input  AMT_W  shift/rotate amount
- in_mode  input  1  0 = logical left shift (zero fill), 1 = rotate left
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_data  output  OUT_W  shifted result
- out_ch  output  SEL_W  channel the result came from
- out_err  output  1  in_sel was >= NCH
- busy  output  1  high in SHIFT or DONE

Behaviour:
- Reset (asynchronous, rst_n = 0): state IDLE. in_ready = 1 after reset release. out_valid, out_data, out_ch, out_err and busy are all 0.
- The FSM has three states: IDLE, SHIFT and DONE.
- IDLE:
  - in_ready = 1. A request is accepted when in_valid & in_ready on a rising edge.
  - On accept, the data register loads the selected word zero-extended to OUT_W. The count register loads in_amt, and the mode, sel and err flags are latched.
  - If in_amt == 0, go to DONE; otherwise go to SHIFT.
- SHIFT:
  - Each cycle the data register shifts left by 1. Logical mode fills bit 0 with 0; rotate mode moves bit OUT_W-1 into bit 0.
  - The count decrements by 1 each cycle. When the count reaches 1 and that last shift is performed, go to DONE.
  - in_ready = 0.
- DONE:
  - out_valid = 1. out_data, out_ch and out_err are held stable until out_valid & out_ready.
  - On that handshake, return to IDLE with out_valid = 0 in the next cycle. out_data keeps its last value.
- Latency: out_valid rises in_amt + 1 cycles after the accepting edge (amt = 0 gives 1 cycle). Throughput is one result per in_amt + 2 cycles minimum.
- Amounts >= OUT_W:
  - Logical mode yields 0.
  - Rotate mode yields the rotation by in_amt mod OUT_W.
  - Both results follow naturally from iteration; no special-casing.
- Invalid select: in_sel >= NCH loads zero data and sets out_err = 1. The transaction still completes normally.
- in_valid asserted outside IDLE is ignored. in_data and in_sel are sampled only on the accepting edge.
- out_ready is ignored outside DONE.
- Reset asserted mid-SHIFT or DONE aborts the transaction immediately with no output. The block is in IDLE after release.

Optional Feature:
- Macro: LSHIFT_NIBBLE_EN.
- Defined: in SHIFT, when the remaining count is >= 4, shift/rotate by 4 and decrement the count by 4. Otherwise step by 1.
  - Latency becomes floor(amt/4) + (amt mod 4) + 1 cycles.
  - Results are bit-identical to the undefined case.
- Undefined: a strict 1-bit step per cycle, as above.

Test Plan:
- Logical shift: ch0 = 4'd13, sel = 0, mode = 0, amt = 3 -> out_data = 16'h0068, out_ch = 0, out_valid exactly 4 cycles after accept (3 with LSHIFT_NIBBLE_EN... also 4, since 0+3+1).
- Rotate wrap: ch1 = 4'd8, sel = 1, mode = 1, amt = 13 -> out_data = 16'h0001.
- Logical shift by the maximum amount: ch0 = 13, mode = 0, amt = 15 -> out_data = 16'h8000.
- Zero amount: ch0 = 13, amt = 0 -> out_data = 16'h000D with out_valid 1 cycle after accept.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE -> out_valid, out_data and out_ch stay stable, in_ready = 0 throughout. in_valid pulses during SHIFT are not accepted.
- Error and reset cases:
  - sel = 1'b1 with NCH = 1 build -> out_err = 1, out_data = 0.
  - Separately, deassert rst_n during SHIFT (amt = 10) -> out_valid = 0, busy = 0, in_ready = 1 after release, no stale result emitted.
